keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Column-scanning driver for a 4-row x 3-column phone keypad.
// Each scan frame is reduced to one key code, debounced, and reported as a level plus an accept pulse.
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] rows,
   output logic [2:0] cols,
   output logic [9:0] keypad,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int AGR_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [AGR_W-1:0] AGR_MAX    = AGR_W'(DEBOUNCE);
   localparam logic [3:0]       CODE_NONE  = 4'hF;

   typedef enum logic [1:0] {COL0, COL1, COL2} col_state_t;

   // Key at (col, row) is addressed as col*4 + row; * and # decode to NONE.
   function automatic logic [3:0] key_digit(input int idx);
      logic [3:0] d;
      case (idx)
         0:       d = 4'd1;
         1:       d = 4'd4;
         2:       d = 4'd7;
         4:       d = 4'd2;
         5:       d = 4'd5;
         6:       d = 4'd8;
         7:       d = 4'd0;
         8:       d = 4'd3;
         9:       d = 4'd6;
         10:      d = 4'd9;
         default: d = CODE_NONE;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] frame_code(input logic [11:0] hit);
      logic [3:0] code;
      int         n;
      code = CODE_NONE;
      n    = 0;
      for (int i = 0; i < 12; i++) begin
         if (hit[i]) begin
            n++;
            code = key_digit(i);
         end
      end
      return (n == 1) ? code : CODE_NONE;
   endfunction

   function automatic logic [9:0] code_onehot(input logic [3:0] code);
      return (code <= 4'd9) ? (10'd1 << code) : 10'd0;
   endfunction

   logic [3:0]       row_p0, row_p1;
   col_state_t       state;
   logic [CNT_W-1:0] dwell;
   logic [7:0]       samp;
   logic [3:0]       cand, stable;
   logic [AGR_W-1:0] agree;

   logic             dwell_end, frame_end, new_digit;
   logic [11:0]      frame_hit;
   logic [3:0]       fcode, cand_nxt, stable_nxt;
   logic [AGR_W-1:0] agree_nxt;

   // Stage p0/p1: two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         row_p0 <= 4'b1111;
         row_p1 <= 4'b1111;
      end else begin
         row_p0 <= rows;
         row_p1 <= row_p0;
      end
   end

   assign dwell_end = (dwell == DWELL_LAST);
   assign frame_end = dwell_end && (state == COL2);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= COL0;
         cols  <= 3'b110;
         dwell <= '0;
         samp  <= '0;
      end else if (dwell_end) begin
         dwell <= '0;
         case (state)
            COL0: begin
               samp[3:0] <= ~row_p1;
               state     <= COL1;
               cols      <= 3'b101;
            end
            COL1: begin
               samp[7:4] <= ~row_p1;
               state     <= COL2;
               cols      <= 3'b011;
            end
            default: begin
               state <= COL0;
               cols  <= 3'b110;
            end
         endcase
      end else begin
         dwell <= dwell + CNT_W'(1);
      end
   end

   // The COL2 sample is taken live on the frame's last clock rather than stored.
   assign frame_hit = {~row_p1, samp};
   assign fcode     = frame_code(frame_hit);

   always_comb begin
      cand_nxt   = cand;
      agree_nxt  = agree;
      stable_nxt = stable;
      if (frame_end) begin
         if (fcode == cand) begin
            if (agree != AGR_MAX) agree_nxt = agree + AGR_W'(1);
         end else begin
            cand_nxt  = fcode;
            agree_nxt = AGR_W'(1);
         end
         if ((agree_nxt == AGR_MAX) && (cand_nxt != stable)) stable_nxt = cand_nxt;
      end
   end

   // keypad still shows the previous stable code for one clock, which marks a fresh digit.
   assign new_digit = (stable != CODE_NONE) && (keypad != code_onehot(stable));

   // Stage boundary: debounce state, then registered outputs one clock behind stable.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cand      <= CODE_NONE;
         stable    <= CODE_NONE;
         agree     <= '0;
         keypad    <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
      end else begin
         cand      <= cand_nxt;
         agree     <= agree_nxt;
         stable    <= stable_nxt;
         keypad    <= code_onehot(stable);
         key_valid <= new_digit;
         if (new_digit) key_code <= stable;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (12-clock frame).
// A behavioural key matrix pulls a row low only while its key is held and its column is driven.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] rows;
   logic [2:0] cols;
   logic [9:0] keypad;
   logic       key_valid;
   logic [3:0] key_code;

   logic [11:0] held;   // bit col*4 + row

   int total = 0;
   int bad   = 0;
   int pulse_total = 0;
   int cols_bad = 0;
   int kp_bad = 0;

   typedef struct {
      logic [11:0] held;
      int          cycles;
      logic [9:0]  exp_keypad;
      logic [3:0]  exp_code;
      int          exp_pulses;
      bit          chk_lat;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs[NV];

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
      .clk      (clk),
      .clr      (clr),
      .rows     (rows),
      .cols     (cols),
      .keypad   (keypad),
      .key_valid(key_valid),
      .key_code (key_code)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'b1111;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            if (held[c*4+r] && !cols[c]) rows[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) pulse_total++;
      if (!(cols inside {3'b110, 3'b101, 3'b011})) cols_bad++;
      if ($countones(keypad) > 1) kp_bad++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, lat;
      logic [9:0] kp_or;
      logic [2:0] exp_cols;

      vecs[0]  = '{12'h020, 60,  10'h020, 4'd5, 1, 1'b1};  // hold 5
      vecs[1]  = '{12'h000, 60,  10'h000, 4'd5, 0, 1'b1};  // release 5
      vecs[2]  = '{12'h011, 60,  10'h000, 4'd5, 0, 1'b0};  // 1 and 2 together
      vecs[3]  = '{12'h008, 60,  10'h000, 4'd5, 0, 1'b0};  // * alone
      vecs[4]  = '{12'h000, 36,  10'h000, 4'd5, 0, 1'b0};
      vecs[5]  = '{12'h004, 60,  10'h080, 4'd7, 1, 1'b1};  // hold 7
      vecs[6]  = '{12'h400, 60,  10'h200, 4'd9, 1, 1'b1};  // roll 7 -> 9
      vecs[7]  = '{12'h400, 240, 10'h200, 4'd9, 0, 1'b0};  // keep holding 9
      vecs[8]  = '{12'h000, 60,  10'h000, 4'd9, 0, 1'b1};
      vecs[9]  = '{12'h800, 60,  10'h000, 4'd9, 0, 1'b0};  // # alone
      vecs[10] = '{12'h000, 36,  10'h000, 4'd9, 0, 1'b0};
      vecs[11] = '{12'h100, 60,  10'h008, 4'd3, 1, 1'b1};  // hold 3
      vecs[12] = '{12'h300, 60,  10'h000, 4'd3, 0, 1'b1};  // add 6 -> two keys
      vecs[13] = '{12'h000, 36,  10'h000, 4'd3, 0, 1'b0};
      vecs[14] = '{12'h040, 60,  10'h100, 4'd8, 1, 1'b1};  // hold 8
      vecs[15] = '{12'h002, 60,  10'h010, 4'd4, 1, 1'b1};  // roll 8 -> 4
      vecs[16] = '{12'h000, 60,  10'h000, 4'd4, 0, 1'b1};

      held = '0;
      clr  = 1'b1;
      repeat (3) step();
      check("reset cols", 32'(cols), 32'h6);
      check("reset keypad", 32'(keypad), 32'h0);
      check("reset key_valid", 32'(key_valid), 32'h0);
      check("reset key_code", 32'(key_code), 32'h0);
      clr = 1'b0;
      repeat (40) step();
      check("idle keypad", 32'(keypad), 32'h0);

      for (int v = 0; v < NV; v++) begin
         held = vecs[v].held;
         base = pulse_total;
         lat  = -1;
         for (int k = 1; k <= vecs[v].cycles; k++) begin
            step();
            if (lat < 0 && keypad === vecs[v].exp_keypad) lat = k;
         end
         check($sformatf("keypad[%0d]", v), 32'(keypad), 32'(vecs[v].exp_keypad));
         check($sformatf("key_code[%0d]", v), 32'(key_code), 32'(vecs[v].exp_code));
         check($sformatf("pulses[%0d]", v), 32'(pulse_total - base), 32'(vecs[v].exp_pulses));
         if (vecs[v].chk_lat) begin
            total++;
            if (lat < 1 || lat > 39) begin
               bad++;
               $display("FAIL latency[%0d]: got %0d clocks, required 1..39", v, lat);
            end
         end
      end

      // One-frame press of 5 must be ignored.
      base  = pulse_total;
      kp_or = '0;
      held  = 12'h020;
      for (int k = 0; k < 12; k++) begin
         step();
         kp_or |= keypad;
      end
      held = '0;
      for (int k = 0; k < 48; k++) begin
         step();
         kp_or |= keypad;
      end
      check("glitch keypad", 32'(kp_or), 32'h0);
      check("glitch key_code", 32'(key_code), 32'h4);
      check("glitch pulses", 32'(pulse_total - base), 32'h0);

      // Press 0, then reset before it can be accepted.
      base = pulse_total;
      held = 12'h080;
      repeat (8) step();
      check("pre-clr pulses", 32'(pulse_total - base), 32'h0);
      clr = 1'b1;
      step();
      check("clr cols", 32'(cols), 32'h6);
      check("clr keypad", 32'(keypad), 32'h0);
      check("clr key_valid", 32'(key_valid), 32'h0);
      check("clr key_code", 32'(key_code), 32'h0);
      repeat (2) step();
      check("clr hold keypad", 32'(keypad), 32'h0);
      base = pulse_total;
      clr  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         exp_cols = (k < 4) ? 3'b110 : (k < 8) ? 3'b101 : 3'b011;
         check($sformatf("cols walk[%0d]", k), 32'(cols), 32'(exp_cols));
         step();
      end
      repeat (48) step();
      check("reaccept keypad", 32'(keypad), 32'h001);
      check("reaccept key_code", 32'(key_code), 32'h0);
      check("reaccept pulses", 32'(pulse_total - base), 32'h1);

      check("cols legal", 32'(cols_bad), 32'h0);
      check("keypad onehot", 32'(kp_bad), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
